// File: rtl/fsk_tape_encoder.sv
// FSK cassette-tape encoder: a word FIFO feeds a shift register whose bits are sent as
// square-wave symbols, timed by a phase accumulator stepped on rising edges of Q.
module fsk_tape_encoder #(
    parameter int              ACC_W     = 24,
    parameter logic [ACC_W-1:0] STP      = 24'd90687,
    parameter int              BITS      = 8,
    parameter int              DEPTH     = 4,
    parameter int              TICKS1    = 2,
    parameter int              TICKS0    = 4,
    parameter int              LSB_FIRST = 1,
    parameter logic            IDLE_LVL  = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Q,
    input  logic            wr,
    input  logic [BITS-1:0] din,
    input  logic            abort,
    output logic            full,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic            dout
);

    localparam int TMAX  = (TICKS0 > TICKS1) ? TICKS0 : TICKS1;
    localparam int TC_W  = $clog2(TMAX);
    localparam int BC_W  = $clog2(BITS) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [TC_W-1:0]  T1_LAST = TC_W'(TICKS1 - 1);
    localparam logic [TC_W-1:0]  T0_LAST = TC_W'(TICKS0 - 1);
    localparam logic [TC_W-1:0]  T1_HALF = TC_W'(TICKS1 / 2);
    localparam logic [TC_W-1:0]  T0_HALF = TC_W'(TICKS0 / 2);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BITS - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    if (BITS < 1 || BITS > 16 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        TICKS1 < 2 || TICKS0 < 2 || (TICKS1 % 2) != 0 || (TICKS0 % 2) != 0) begin : g_bad_param
        $error("fsk_tape_encoder: illegal parameter combination");
    end

    logic [0:0]       state;
    logic             q_d;
    logic             tick;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [BITS-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [BITS-1:0]  shreg, shreg_next;
    logic [BC_W-1:0]  bitcnt;
    logic [TC_W-1:0]  tickcnt, t_last, t_half;
    logic             sending, qedge, cur_bit, sym_end, word_end, empty, push, pop;

    always_comb begin
        acc_sum    = {1'b0, acc} + {1'b0, STP};
        qedge      = Q & ~q_d;
        sending    = (state == S_SEND);
        cur_bit    = (LSB_FIRST != 0) ? shreg[0] : shreg[BITS-1];
        shreg_next = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
        t_last     = cur_bit ? T1_LAST : T0_LAST;
        t_half     = cur_bit ? T1_HALF : T0_HALF;
        sym_end    = sending && tick && (tickcnt == t_last);
        word_end   = sym_end && (bitcnt == BC_LAST);
        empty      = (count == '0);
        full       = (count == CNT_FULL);
        // A pop happens on a load from IDLE or at a word boundary; abort suppresses both.
        pop        = !abort && !empty && (!sending || word_end);
        push       = wr && !full && !abort;
        done       = word_end && !abort;
        busy       = sending;
        dout       = sending ? (tickcnt < t_half) : IDLE_LVL;
    end

    // NOTE: the FIFO storage has no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            q_d     <= 1'b0;
            tick    <= 1'b0;
            acc     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            shreg   <= '0;
            bitcnt  <= '0;
            tickcnt <= '0;
            ovf     <= 1'b0;
        end else begin
            q_d <= Q;
            if (wr && full && !abort) ovf <= 1'b1;
            if (abort) begin
                state   <= S_IDLE;
                tick    <= 1'b0;
                acc     <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                bitcnt  <= '0;
                tickcnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

                tick <= 1'b0;
                if (sending && qedge) begin
                    acc  <= acc_sum[ACC_W-1:0];
                    tick <= acc_sum[ACC_W];
                end

                if (!sending) begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        bitcnt  <= '0;
                        tickcnt <= '0;
                        acc     <= '0;
                        state   <= S_SEND;
                    end
                end else if (tick) begin
                    if (sym_end) begin
                        tickcnt <= '0;
                        bitcnt  <= bitcnt + 1'b1;
                        shreg   <= shreg_next;
                        // Back-to-back words keep the accumulator phase so dout has no gap.
                        if (word_end) begin
                            if (pop) begin
                                shreg  <= mem[rd_ptr];
                                bitcnt <= '0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end else begin
                        tickcnt <= tickcnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fsk_tape_encoder.sv
// Scoreboard bench: two encoders (LSB-first and MSB-first) share stimulus; a monitor decodes
// each dout waveform back into words by low-run length and compares against queued writes.
module tb_fsk_tape_encoder;

    logic       clk = 1'b0;
    logic       reset, Q, wr, abort;
    logic [7:0] din;
    logic       full0, busy0, done0, ovf0, dout0;
    logic       full1, busy1, done1, ovf1, dout1;

    int         n_checks = 0;
    int         n_err    = 0;
    int         qp       = 10;
    bit         q_run    = 1'b0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    always #5 clk = ~clk;

    fsk_tape_encoder #(.ACC_W(24), .STP(24'h800000), .BITS(8), .DEPTH(4), .TICKS1(2),
                       .TICKS0(4), .LSB_FIRST(1), .IDLE_LVL(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .Q(Q), .wr(wr), .din(din), .abort(abort),
        .full(full0), .busy(busy0), .done(done0), .ovf(ovf0), .dout(dout0));

    fsk_tape_encoder #(.ACC_W(24), .STP(24'h800000), .BITS(8), .DEPTH(4), .TICKS1(2),
                       .TICKS0(4), .LSB_FIRST(0), .IDLE_LVL(1'b0)) u_msb (
        .clk(clk), .reset(reset), .Q(Q), .wr(wr), .din(din), .abort(abort),
        .full(full1), .busy(busy1), .done(done1), .ovf(ovf1), .dout(dout1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Q: square wave of qp clk cycles, one rising edge per period.
    initial begin
        int qc = 0;
        Q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (q_run) begin
                qc++;
                if (qc >= qp) qc = 0;
                Q = (qc < qp / 2);
            end else begin
                Q = 1'b0;
            end
        end
    end

    // With STP = 2^23 a tick arrives every 2 Q periods; a 1 symbol is low for 1 tick
    // interval (2*qp clk), a 0 symbol for 2 intervals (4*qp clk).
    int         low_cnt [2];
    int         nb      [2];
    logic [7:0] bits_v  [2];
    logic       m_busy, m_dout, m_done;
    logic [7:0] m_word, m_exp;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_busy = (i == 0) ? busy0 : busy1;
            m_dout = (i == 0) ? dout0 : dout1;
            m_done = (i == 0) ? done0 : done1;
            if (!m_busy) begin
                if (m_done) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL done_while_idle[%0d]: got done=1, expected 0", i);
                end
                low_cnt[i] = 0;
                nb[i]      = 0;
            end else begin
                if (m_dout) begin
                    if (low_cnt[i] > 0) begin
                        if (nb[i] < 8) bits_v[i][nb[i]] = (low_cnt[i] < 3 * qp);
                        nb[i]++;
                        low_cnt[i] = 0;
                    end
                end else begin
                    low_cnt[i]++;
                end
                if (m_done) begin
                    if (nb[i] < 8) bits_v[i][nb[i]] = (low_cnt[i] < 3 * qp);
                    nb[i]++;
                    low_cnt[i] = 0;
                    for (int k = 0; k < 8; k++) m_word[(i == 0) ? k : 7 - k] = bits_v[i][k];
                    if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_done[%0d]: got word 0x%0h, expected none", i, m_word);
                    end else begin
                        m_exp = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check(i == 0 ? "symbols_lsb" : "symbols_msb", nb[i], 8);
                        check(i == 0 ? "word_lsb" : "word_msb", m_word, m_exp);
                    end
                    nb[i] = 0;
                end
            end
        end
    end

    // Stimulus tasks start and end at posedge + #1.
    task automatic do_write(input logic [7:0] d, input bit accept);
        wr  = 1'b1;
        din = d;
        if (accept) begin
            exp_q0.push_back(d);
            exp_q1.push_back(d);
        end
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int c = 0; c < 8000 && !ok; c++) begin
            @(negedge clk);
            ok = (exp_q0.size() == 0) && (exp_q1.size() == 0) && !busy0 && !busy1;
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: got %0d/%0d words pending, expected 0", exp_q0.size(), exp_q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gap, seen;
        reset = 1'b1; wr = 1'b0; abort = 1'b0; din = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  {busy1, busy0}, 2'b00);
        check("rst_full",  {full1, full0}, 2'b00);
        check("rst_done",  {done1, done0}, 2'b00);
        check("rst_ovf",   {ovf1, ovf0},   2'b00);
        check("rst_dout",  {dout1, dout0}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single word 8'h01, Q period 10
        qp = 10; q_run = 1'b1;
        do_write(8'h01, 1'b1);
        drain();
        check("single_idle_dout", {dout1, dout0}, 2'b00);

        // Back-to-back 8'hFF then 8'h00: no idle cycle between words
        qp = 6;
        do_write(8'hFF, 1'b1);
        do_write(8'h00, 1'b1);
        gap = 0; seen = 0;
        for (int c = 0; c < 4000 && seen < 2; c++) begin
            @(negedge clk);
            if (done0) seen++;
            if (!busy0) gap++;
        end
        check("b2b_done_count", seen, 2);
        check("b2b_idle_gap", gap, 0);
        drain();

        // Overflow: Q held low, first word stalls, 4 queued, 6th dropped
        q_run = 1'b0;
        repeat (2) @(posedge clk); #1;
        for (int n = 0; n < 6; n++) do_write(8'h10 + 8'(n * 17), n < 5);
        check("ovf_full", {full1, full0}, 2'b11);
        check("ovf_flag", {ovf1, ovf0},   2'b11);
        // Write while full in the same clk as the word-end pop: still dropped
        q_run = 1'b1;
        seen = 0;
        for (int c = 0; c < 4000 && seen == 0; c++) begin
            @(negedge clk);
            if (done0) begin
                seen = 1;
                wr = 1'b1;
                din = 8'hA5;
            end
        end
        check("ovf_pop_seen", seen, 1);
        @(posedge clk); #1;
        wr = 1'b0;
        check("ovf_pop_drop_full", {full1, full0}, 2'b00);
        check("ovf_sticky", {ovf1, ovf0}, 2'b11);
        drain();

        // Abort mid-word with 2 words queued
        qp = 4 + int'($urandom_range(4));
        for (int n = 0; n < 3; n++) do_write(8'($urandom), 1'b1);
        repeat (8 * qp) @(posedge clk); #1;
        abort = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", {busy1, busy0}, 2'b00);
        check("abort_dout", {dout1, dout0}, 2'b00);
        check("abort_full", {full1, full0}, 2'b00);
        check("abort_ovf_kept", {ovf1, ovf0}, 2'b11);
        repeat (50) @(posedge clk); #1;
        check("abort_fifo_empty", {busy1, busy0}, 2'b00);

        // Asynchronous reset mid-symbol
        do_write(8'($urandom), 1'b1);
        repeat (5 * qp + 1) @(posedge clk);
        #3;
        reset = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check("arst_busy", {busy1, busy0}, 2'b00);
        check("arst_dout", {dout1, dout0}, 2'b00);
        check("arst_ovf",  {ovf1, ovf0},   2'b00);
        check("arst_done", {done1, done0}, 2'b00);
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        repeat (60) @(posedge clk); #1;
        check("arst_no_resume", {busy1, busy0}, 2'b00);

        // Randomised bursts of up to DEPTH words
        for (int b = 0; b < 6; b++) begin
            qp = 4 + int'($urandom_range(4));
            for (int n = 0; n <= int'($urandom_range(3)); n++) begin
                do_write(8'($urandom), 1'b1);
                repeat ($urandom_range(3)) @(posedge clk);
                #0;
            end
            drain();
        end

        check("sb_empty_lsb", exp_q0.size(), 0);
        check("sb_empty_msb", exp_q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fsk_tape_encoder.md
FSK_TAPE_ENCODER -- requirements
Module: fsk_tape_encoder

Interface
REQ-001 Parameter STP, 24'd90687: phase-accumulator increment added on each Q rising edge while sending.
REQ-002 Parameter ACC_W, 24: phase-accumulator width in bits; the carry out of bit ACC_W-1 is the symbol tick.
REQ-003 Parameter BITS, 8: bits per word; the legal range SHALL be 1..16.
REQ-004 Parameter DEPTH, 4: word FIFO depth; it SHALL be a power of two, 2..16.
REQ-005 Parameter TICKS1, 2: ticks per bit-1 symbol; it SHALL be even and at least 2.
REQ-006 Parameter TICKS0, 4: ticks per bit-0 symbol; it SHALL be even and at least 2.
REQ-007 Parameter LSB_FIRST, 1: 1 sends bit 0 of each word first; 0 sends bit BITS-1 first.
REQ-008 Parameter IDLE_LVL, 1'b0: dout level when no word is being sent.
REQ-009 clk  in  1  system clock; all state changes on its rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 Q  in  1  slow timing reference; only its rising edges, detected in the clk domain, advance the accumulator.
REQ-012 wr  in  1  one-clk write strobe for din.
REQ-013 din  in  BITS  word to enqueue.
REQ-014 abort  in  1  synchronous flush of the FIFO and the current word.
REQ-015 full  out  1  the FIFO holds DEPTH words.
REQ-016 busy  out  1  a word is being sent.
REQ-017 done  out  1  one-clk pulse at the end of each word.
REQ-018 ovf  out  1  sticky flag: a write was dropped.
REQ-019 dout  out  1  FSK cassette output.

Function
REQ-020 wr SHALL be accepted iff full=0 in that cycle; a wr while full=1 SHALL be dropped and SHALL set ovf, including when a pop occurs in the same cycle.
REQ-021 A simultaneous accepted write and pop SHALL leave the FIFO count unchanged; order SHALL be first in, first out.
REQ-022 Q edge detection: qedge=1 when Q=1 and the registered previous Q=0; one edge SHALL be counted per Q low-to-high transition.
REQ-023 On qedge while state=SEND: {carry, acc} <= acc + STP; the registered carry SHALL form a one-clk tick.
REQ-024 The accumulator and tickcnt SHALL be cleared when a word is loaded from IDLE; they SHALL not be cleared on back-to-back loads.
REQ-025 State machine has two states, IDLE and SEND.
REQ-026 IDLE: if the FIFO is not empty, pop the head into the shift register, set bitcnt=0 and tickcnt=0, and enter SEND on the next clk.
REQ-027 SEND, on each tick: tickcnt increments; when tickcnt equals T-1, where T=TICKS1 if the current bit is 1 and TICKS0 otherwise, clear tickcnt, shift to the next bit and increment bitcnt.
REQ-028 On the tick that ends bit BITS-1, done SHALL pulse in the same clk.
REQ-029 At that word end with the FIFO not empty: pop the next word in the same clk and stay in SEND, with no gap in dout.
REQ-030 At that word end with the FIFO empty: enter IDLE.
REQ-031 In SEND, dout SHALL be 1 while tickcnt < T/2 and 0 otherwise; in IDLE, dout SHALL equal IDLE_LVL.
REQ-032 busy SHALL equal (state==SEND).
REQ-033 abort SHALL empty the FIFO, force IDLE and clear acc and tickcnt on the next clk, with no done pulse; abort SHALL take priority over wr and ticks in that cycle, and ovf SHALL be unaffected.
REQ-034 A tick and a qedge in the same clk SHALL both take effect, with no lost tick.
REQ-035 bitcnt SHALL be sized clog2(BITS)+1 bits; tickcnt SHALL be sized to hold max(TICKS0,TICKS1)-1.

Reset
REQ-036 While reset=1: FIFO empty, state=IDLE, acc=0, tickcnt=0, bitcnt=0, registered Q=0, full=0, busy=0, done=0, ovf=0, dout=IDLE_LVL.
REQ-037 Reset asserted mid-word SHALL abandon the word immediately; only reset SHALL clear ovf.

Verification
REQ-038 Single word: STP=2^23, ACC_W=24, Q period 10 clk, wr din=8'h01 -> tick every 2 Q edges; dout 1,0 for bit0 then 1,1,0,0 per zero bit; done once after 30 ticks; busy then 0.
REQ-039 Back-to-back: write 8'hFF then 8'h00 -> 16 ticks then 32 ticks continuous, exactly 2 done pulses, busy stays 1 with no idle cycle between words.
REQ-040 Overflow: DEPTH=4, Q held low, 6 writes -> the first word loads and stalls in SEND, 4 words are queued, full=1, the 6th write is dropped and ovf=1; then wr with a same-clk pop while full -> still dropped.
REQ-041 MSB-first: LSB_FIRST=0, din=8'h80 -> the first symbol is 2 ticks and the next 7 symbols are 4 ticks each.
REQ-042 Abort: abort mid-word with 2 words queued -> next clk busy=0, dout=IDLE_LVL, FIFO empty, no done pulse.
REQ-043 Reset: assert reset mid-symbol -> all outputs take their reset values asynchronously; after release the encoder resumes only on a new wr.
